// File: rtl/lcd_8080_responder.sv
// lcd_8080_responder
//   Panel-side model of an 8080-style LCD bus. It synchronises the bus pins,
//   decodes CASET (0x2A), PASET (0x2B), RAMWR (0x2C), RDID (0x04) and
//   SWRESET (0x01), and turns RAMWR data into an addressed pixel stream.
//
//   Optional feature macro: LCD_RESP_RDID_EN
//     defined   : read path active, RDID returns ID_VALUE bytes
//     undefined : lcd_data_oe/lcd_data_out tied 0, 0x04 treated as unknown
//
// Ports
//   clk_clk, reset_reset_n         : clock, synchronous active-low reset
//   lcd_cs_n, lcd_data_cmd_n       : chip select (low), 1=data 0=command
//   lcd_wr_n, lcd_rd_n             : write strobe (rising edge), read strobe
//   lcd_lcdreset_n                 : panel hardware reset (low)
//   lcd_data_in / lcd_data_out     : bus data in / read data out
//   lcd_data_oe                    : read data drives the bus
//   cmd_strobe, cmd_code           : pulse + code of each accepted command
//   pix_valid, pix_data,pix_x,pix_y: pulse + RGB565 pixel and coordinates
//   frame_done                     : pulse with the pixel at (EC,EP)
module lcd_8080_responder #(
    parameter logic [15:0] ID_VALUE = 16'h9341,
    parameter int          COORD_W  = 9,
    parameter int          SYNC_STG = 2
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic               lcd_cs_n,
    input  logic               lcd_data_cmd_n,
    input  logic               lcd_wr_n,
    input  logic               lcd_rd_n,
    input  logic               lcd_lcdreset_n,
    input  logic [15:0]        lcd_data_in,
    output logic [15:0]        lcd_data_out,
    output logic               lcd_data_oe,
    output logic               cmd_strobe,
    output logic [7:0]         cmd_code,
    output logic               pix_valid,
    output logic [15:0]        pix_data,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               frame_done
);

    typedef enum logic [2:0] {S_IDLE, S_CASET, S_PASET, S_RAMWR, S_RDID} state_t;

    // ---------------- input synchronisers ----------------
    logic [SYNC_STG-1:0]       cs_s_q, dc_s_q, wr_s_q, rst_s_q;
    logic [SYNC_STG-1:0][15:0] dat_s_q;
    logic                      wr_prev_q;

    // The edge-detect history is deliberately outside the panel reset so a
    // strobe held across lcdreset cannot create a phantom edge afterwards.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            cs_s_q    <= '1;
            dc_s_q    <= '0;
            wr_s_q    <= '1;
            rst_s_q   <= '1;
            dat_s_q   <= '0;
            wr_prev_q <= 1'b1;
        end else begin
            cs_s_q    <= {cs_s_q[SYNC_STG-2:0], lcd_cs_n};
            dc_s_q    <= {dc_s_q[SYNC_STG-2:0], lcd_data_cmd_n};
            wr_s_q    <= {wr_s_q[SYNC_STG-2:0], lcd_wr_n};
            rst_s_q   <= {rst_s_q[SYNC_STG-2:0], lcd_lcdreset_n};
            dat_s_q   <= {dat_s_q[SYNC_STG-2:0], lcd_data_in};
            wr_prev_q <= wr_s_q[SYNC_STG-1];
        end
    end

    logic        cs_n_s, dc_s, wr_s, wr_ev, cmd_wr, dat_wr, swrst, panel_rst;
    logic [15:0] din_s;
    assign cs_n_s    = cs_s_q[SYNC_STG-1];
    assign dc_s      = dc_s_q[SYNC_STG-1];
    assign wr_s      = wr_s_q[SYNC_STG-1];
    assign din_s     = dat_s_q[SYNC_STG-1];
    assign panel_rst = !rst_s_q[SYNC_STG-1];
    assign wr_ev     = wr_s && !wr_prev_q && !cs_n_s;
    assign cmd_wr    = wr_ev && !dc_s;
    assign dat_wr    = wr_ev && dc_s;
    assign swrst     = cmd_wr && (din_s[7:0] == 8'h01);

`ifdef LCD_RESP_RDID_EN
    logic [SYNC_STG-1:0] rd_s_q;
    logic                rd_prev_q;
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            rd_s_q    <= '1;
            rd_prev_q <= 1'b1;
        end else begin
            rd_s_q    <= {rd_s_q[SYNC_STG-2:0], lcd_rd_n};
            rd_prev_q <= rd_s_q[SYNC_STG-1];
        end
    end

    logic rd_s, rd_ev;
    assign rd_s  = rd_s_q[SYNC_STG-1];
    // A write in the same cycle wins; the read start is dropped.
    assign rd_ev = !rd_s && rd_prev_q && !cs_n_s && !wr_ev;

    logic [2:0]  ridx_q;
    logic [15:0] rd_word;
    logic        oe_q;
    logic [15:0] dout_q;
    always_comb begin
        rd_word = '0;
        case (ridx_q)
            3'd2:    rd_word = {8'h00, ID_VALUE[15:8]};
            3'd3:    rd_word = {8'h00, ID_VALUE[7:0]};
            default: rd_word = '0;
        endcase
    end
`endif

    // ---------------- command / pixel engine ----------------
    state_t             state_q;
    logic [1:0]         pcnt_q;
    logic [2:0][7:0]    prm_q;
    logic [COORD_W-1:0] sc_q, ec_q, sp_q, ep_q, x_q, y_q, x_d, y_d;
    logic               wrap_x, wrap_y;
    logic [15:0]        rng_lo, rng_hi;
    logic               cmd_strobe_q, pix_valid_q, frame_done_q;
    logic [7:0]         cmd_code_q;
    logic [15:0]        pix_data_q;
    logic [COORD_W-1:0] pix_x_q, pix_y_q;

    assign rng_lo = {prm_q[0], prm_q[1]};
    assign rng_hi = {prm_q[2], din_s[7:0]};

    // ">=" rather than "==" so a start>end window wraps on every pixel
    // instead of running off through the whole coordinate space.
    always_comb begin
        wrap_x = (x_q >= ec_q);
        wrap_y = (y_q >= ep_q);
        x_d    = x_q + 1'b1;
        y_d    = y_q;
        if (wrap_x) begin
            x_d = sc_q;
            y_d = wrap_y ? sp_q : y_q + 1'b1;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n || panel_rst || swrst) begin
            state_q      <= S_IDLE;
            pcnt_q       <= '0;
            prm_q        <= '0;
            sc_q         <= '0;
            sp_q         <= '0;
            ec_q         <= '1;
            ep_q         <= '1;
            x_q          <= '0;
            y_q          <= '0;
            cmd_strobe_q <= 1'b0;
            cmd_code_q   <= '0;
            pix_valid_q  <= 1'b0;
            pix_data_q   <= '0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            frame_done_q <= 1'b0;
`ifdef LCD_RESP_RDID_EN
            ridx_q       <= '0;
            oe_q         <= 1'b0;
            dout_q       <= '0;
`endif
        end else begin
            cmd_strobe_q <= 1'b0;
            pix_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            if (cmd_wr) begin
                cmd_strobe_q <= 1'b1;
                cmd_code_q   <= din_s[7:0];
                pcnt_q       <= '0;
                case (din_s[7:0])
                    8'h2A: state_q <= S_CASET;
                    8'h2B: state_q <= S_PASET;
                    8'h2C: begin
                        state_q <= S_RAMWR;
                        x_q     <= sc_q;
                        y_q     <= sp_q;
                    end
`ifdef LCD_RESP_RDID_EN
                    8'h04: begin
                        state_q <= S_RDID;
                        ridx_q  <= '0;
                    end
`endif
                    default: state_q <= S_IDLE;
                endcase
            end else if (dat_wr) begin
                case (state_q)
                    S_CASET, S_PASET: begin
                        if (pcnt_q == 2'd3) begin
                            if (state_q == S_CASET) begin
                                sc_q <= rng_lo[COORD_W-1:0];
                                ec_q <= rng_hi[COORD_W-1:0];
                            end else begin
                                sp_q <= rng_lo[COORD_W-1:0];
                                ep_q <= rng_hi[COORD_W-1:0];
                            end
                            pcnt_q  <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            prm_q[pcnt_q] <= din_s[7:0];
                            pcnt_q        <= pcnt_q + 1'b1;
                        end
                    end
                    S_RAMWR: begin
                        pix_valid_q  <= 1'b1;
                        pix_data_q   <= din_s;
                        pix_x_q      <= x_q;
                        pix_y_q      <= y_q;
                        frame_done_q <= wrap_x && wrap_y;
                        x_q          <= x_d;
                        y_q          <= y_d;
                    end
                    default: ;
                endcase
            end
`ifdef LCD_RESP_RDID_EN
            if (rd_ev) begin
                oe_q   <= 1'b1;
                dout_q <= (state_q == S_RDID) ? rd_word : 16'h0000;
                if (state_q == S_RDID && ridx_q != 3'd4)
                    ridx_q <= ridx_q + 1'b1;
            end else if (rd_s || cs_n_s) begin
                oe_q   <= 1'b0;
                dout_q <= '0;
            end
`endif
        end
    end

    assign cmd_strobe = cmd_strobe_q;
    assign cmd_code   = cmd_code_q;
    assign pix_valid  = pix_valid_q;
    assign pix_data   = pix_data_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign frame_done = frame_done_q;
`ifdef LCD_RESP_RDID_EN
    assign lcd_data_oe  = oe_q;
    assign lcd_data_out = dout_q;
`else
    logic unused_rd;
    assign unused_rd    = ^{lcd_rd_n, ID_VALUE};
    assign lcd_data_oe  = 1'b0;
    assign lcd_data_out = '0;
`endif

endmodule
